// File: rtl/stage_output_mixer_pkg.sv
// Shared constants, types and helpers for the operator output mixer.
// This package owns the frame geometry and the carrier-flag position in the algorithm word.
package stage_output_mixer_pkg;

    localparam int NUM_VOICES              = 16;
    localparam int NUM_OPERATORS           = 8;
    localparam int VOICE_BITS              = $clog2(NUM_VOICES);
    localparam int OPERATOR_BITS           = $clog2(NUM_OPERATORS);
    localparam int VOICE_OPERATOR_ID_WIDTH = VOICE_BITS + OPERATOR_BITS;
    localparam int ALGORITHM_WORD_WIDTH    = 8;
    localparam int CARRIER_BIT             = 0;

    typedef logic [VOICE_OPERATOR_ID_WIDTH-1:0] voice_operator_id_t;
    typedef logic [ALGORITHM_WORD_WIDTH-1:0]    algorithm_word_t;

    localparam voice_operator_id_t LAST_VOICE_OPERATOR_ID =
        voice_operator_id_t'(NUM_VOICES * NUM_OPERATORS - 1);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } mixer_state_t;

    function automatic voice_operator_id_t make_voice_operator_id(
        input logic [VOICE_BITS-1:0]    voice,
        input logic [OPERATOR_BITS-1:0] operator_index
    );
        return {voice, operator_index};
    endfunction

    function automatic logic [VOICE_BITS-1:0] get_voice_id(input voice_operator_id_t id);
        return id[VOICE_OPERATOR_ID_WIDTH-1:OPERATOR_BITS];
    endfunction

    function automatic logic get_is_carrier(input algorithm_word_t word);
        return word[CARRIER_BIT];
    endfunction

endpackage

// File: rtl/stage_output_mixer_saturate_shift.sv
// Arithmetic right shift of a wide signed sum followed by clamping to signed 16 bits.
// Purely combinational so later output stages can reuse it.
module stage_output_mixer_saturate_shift #(
    parameter int IN_WIDTH = 24,
    parameter int SHIFT    = 3
) (
    input  logic signed [IN_WIDTH-1:0] value,
    output logic signed [15:0]         result
);

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = {{(IN_WIDTH-16){1'b0}}, 16'h7fff};
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = {{(IN_WIDTH-16){1'b1}}, 16'h8000};

    logic signed [IN_WIDTH-1:0] shifted_s;

    assign shifted_s = value >>> SHIFT;

    // Clamp the shifted sum into the 16-bit sample range.
    always_comb begin
        if (shifted_s > SAT_MAX) begin
            result = 16'sh7fff;
        end else if (shifted_s < SAT_MIN) begin
            result = 16'sh8000;
        end else begin
            result = shifted_s[15:0];
        end
    end

endmodule

// File: rtl/stage_output_mixer.sv
// Final operator stage: writes operator results back to the modulator and mixes carrier
// operators over a full frame into one saturated 16-bit sample, flagging sequence faults.
module stage_output_mixer
    import stage_output_mixer_pkg::*;
#(
    parameter int ACC_WIDTH  = 24,
    parameter int GAIN_SHIFT = 3
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset,
    input  logic                                i_Valid,
    input  logic [VOICE_OPERATOR_ID_WIDTH-1:0]  i_VoiceOperator,
    input  logic [ALGORITHM_WORD_WIDTH-1:0]     i_AlgorithmWord,
    input  logic                                i_NoteOn,
    input  logic signed [15:0]                  i_OperatorOutput,
    output logic [VOICE_OPERATOR_ID_WIDTH-1:0]  o_OperatorWritebackID,
    output logic signed [15:0]                  o_OperatorWritebackValue,
    output logic signed [15:0]                  o_Sample,
    output logic                                o_SampleValid,
    output logic                                o_FrameError
);

    logic                                s1_valid_r;
    logic                                s1_first_r;
    logic                                s1_last_r;
    logic [VOICE_OPERATOR_ID_WIDTH-1:0]  s1_id_r;
    logic signed [ACC_WIDTH-1:0]         s1_contrib_r;

    mixer_state_t                        state_r;
    mixer_state_t                        state_nxt_s;
    logic [VOICE_OPERATOR_ID_WIDTH-1:0]  expected_r;
    logic [VOICE_OPERATOR_ID_WIDTH-1:0]  expected_nxt_s;
    logic signed [ACC_WIDTH-1:0]         acc_r;
    logic signed [ACC_WIDTH-1:0]         acc_nxt_s;
    logic signed [ACC_WIDTH-1:0]         sum_s;
    logic signed [15:0]                  mixed_s;
    logic                                emit_s;
    logic                                error_s;

    assign sum_s = acc_r + s1_contrib_r;

    stage_output_mixer_saturate_shift #(
        .IN_WIDTH (ACC_WIDTH),
        .SHIFT    (GAIN_SHIFT)
    ) u_saturate_shift (
        .value  (sum_s),
        .result (mixed_s)
    );

    // Writeback register: holds across idle slots since the modulator rewrites every clock.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_OperatorWritebackID    <= '0;
            o_OperatorWritebackValue <= 16'sd0;
        end else if (i_Valid) begin
            o_OperatorWritebackID    <= i_VoiceOperator;
            o_OperatorWritebackValue <= i_NoteOn ? i_OperatorOutput : 16'sd0;
        end
    end

    // Stage 1: gate and sign-extend the carrier contribution, tag frame boundaries.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1_valid_r   <= 1'b0;
            s1_first_r   <= 1'b0;
            s1_last_r    <= 1'b0;
            s1_id_r      <= '0;
            s1_contrib_r <= '0;
        end else begin
            s1_valid_r   <= i_Valid;
            s1_first_r   <= (i_VoiceOperator == '0);
            s1_last_r    <= (i_VoiceOperator == LAST_VOICE_OPERATOR_ID);
            s1_id_r      <= i_VoiceOperator;
            if (i_Valid && i_NoteOn && get_is_carrier(i_AlgorithmWord)) begin
                s1_contrib_r <= {{(ACC_WIDTH-16){i_OperatorOutput[15]}}, i_OperatorOutput};
            end else begin
                s1_contrib_r <= '0;
            end
        end
    end

    // Stage 2 sequencing: frame sync, accumulate, sample emission and fault detection.
    always_comb begin
        state_nxt_s    = state_r;
        expected_nxt_s = expected_r;
        acc_nxt_s      = acc_r;
        emit_s         = 1'b0;
        error_s        = 1'b0;
        if (s1_valid_r) begin
            case (state_r)
                WAIT_SYNC: begin
                    if (s1_first_r) begin
                        acc_nxt_s      = s1_contrib_r;
                        expected_nxt_s = VOICE_OPERATOR_ID_WIDTH'(1);
                        state_nxt_s    = RUN;
                    end else begin
                        state_nxt_s    = WAIT_SYNC;
                    end
                end
                RUN: begin
                    if (s1_id_r == expected_r) begin
                        acc_nxt_s = s1_first_r ? s1_contrib_r : sum_s;
                        if (s1_last_r) begin
                            emit_s         = 1'b1;
                            expected_nxt_s = '0;
                        end else begin
                            expected_nxt_s = expected_r + VOICE_OPERATOR_ID_WIDTH'(1);
                        end
                    end else begin
                        // A stray ID 0 is taken as the start of a fresh frame rather than lost.
                        error_s = 1'b1;
                        if (s1_first_r) begin
                            acc_nxt_s      = s1_contrib_r;
                            expected_nxt_s = VOICE_OPERATOR_ID_WIDTH'(1);
                        end else begin
                            state_nxt_s    = WAIT_SYNC;
                        end
                    end
                end
                default: begin
                    state_nxt_s = WAIT_SYNC;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Stage 2 state and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r       <= WAIT_SYNC;
            expected_r    <= '0;
            acc_r         <= '0;
            o_Sample      <= 16'sd0;
            o_SampleValid <= 1'b0;
            o_FrameError  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            expected_r    <= expected_nxt_s;
            acc_r         <= acc_nxt_s;
            o_SampleValid <= emit_s;
            o_FrameError  <= error_s;
            if (emit_s) begin
                o_Sample <= mixed_s;
            end
        end
    end

endmodule

// File: tb/tb_stage_output_mixer.sv
// Scoreboard bench for stage_output_mixer: two instances (gain shift 0 and 3) share one stimulus
// stream; the driver queues expected responses and negedge monitors pop and compare them.
module tb_stage_output_mixer;
    import stage_output_mixer_pkg::*;

    typedef struct { int due; int value; } exp_t;
    typedef struct { int due; int id; int value; } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid = 1'b0;
    logic [VOICE_OPERATOR_ID_WIDTH-1:0] vo_id = '0;
    logic [ALGORITHM_WORD_WIDTH-1:0]    alg = '0;
    logic note_on = 1'b0;
    logic signed [15:0] op_out = 16'sd0;

    logic [VOICE_OPERATOR_ID_WIDTH-1:0] wb_id0, wb_id3;
    logic signed [15:0] wb_val0, wb_val3, sample0, sample3;
    logic sv0, sv3, fe0, fe3;

    int cyc = 0;
    int vectors = 0;
    int fails = 0;
    int wb_id_m = 0;
    int wb_val_m = 0;

    exp_t sample_q0[$];
    exp_t sample_q3[$];
    exp_t err_q0[$];
    exp_t err_q3[$];
    wb_t  wb_q[$];

    stage_output_mixer #(.ACC_WIDTH(24), .GAIN_SHIFT(0)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .i_VoiceOperator(vo_id),
        .i_AlgorithmWord(alg), .i_NoteOn(note_on), .i_OperatorOutput(op_out),
        .o_OperatorWritebackID(wb_id0), .o_OperatorWritebackValue(wb_val0),
        .o_Sample(sample0), .o_SampleValid(sv0), .o_FrameError(fe0));

    stage_output_mixer #(.ACC_WIDTH(24), .GAIN_SHIFT(3)) dut3 (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .i_VoiceOperator(vo_id),
        .i_AlgorithmWord(alg), .i_NoteOn(note_on), .i_OperatorOutput(op_out),
        .o_OperatorWritebackID(wb_id3), .o_OperatorWritebackValue(wb_val3),
        .o_Sample(sample3), .o_SampleValid(sv3), .o_FrameError(fe3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one slot just after a rising edge and queue the writeback it should produce.
    task automatic drive(input logic v, input int id, input logic car, input logic non,
                         input int val, input logic r);
        wb_t w;
        @(posedge clk);
        #1;
        rst     = r;
        valid   = v;
        vo_id   = VOICE_OPERATOR_ID_WIDTH'(id);
        alg     = 8'h5a;
        alg[CARRIER_BIT] = car;
        note_on = non;
        op_out  = 16'(val);
        if (r) begin
            wb_id_m  = 0;
            wb_val_m = 0;
        end else if (v) begin
            wb_id_m  = id;
            wb_val_m = non ? val : 0;
        end
        w.due = cyc + 1;
        w.id = wb_id_m;
        w.value = wb_val_m;
        wb_q.push_back(w);
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic slot(input int id, input logic car, input int val);
        drive(1'b1, id, car, 1'b1, val, 1'b0);
    endtask

    task automatic expect_sample(input int e0, input int e3);
        sample_q0.push_back('{cyc + 2, e0});
        sample_q3.push_back('{cyc + 2, e3});
    endtask

    task automatic expect_error();
        err_q0.push_back('{cyc + 2, 1});
        err_q3.push_back('{cyc + 2, 1});
    endtask

    // Full frame 0..127: IDs below ncar are carriers at cval, the rest non-carriers at 1000.
    task automatic frame(input int ncar, input int cval, input logic non, input int gap_at,
                         input int gap_len, input int e0, input int e3);
        for (int id = 0; id < 128; id++) begin
            drive(1'b1, id, id < ncar, non, (id < ncar) ? cval : 1000, 1'b0);
            if (id == 127) expect_sample(e0, e3);
            if (id == gap_at) repeat (gap_len) idle();
        end
    endtask

    // Writeback monitor: compares both instances against the queued model value.
    always @(negedge clk) begin
        wb_t w;
        if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
            w = wb_q.pop_front();
            check("wb_id_g0", int'(wb_id0), w.id);
            check("wb_val_g0", int'(wb_val0), w.value);
            check("wb_id_g3", int'(wb_id3), w.id);
            check("wb_val_g3", int'(wb_val3), w.value);
        end
    end

    // Sample/error monitor for the gain-shift-0 instance.
    always @(negedge clk) begin
        exp_t e;
        if (sv0) begin
            if (sample_q0.size() == 0) check("unexpected_sample_g0", int'(sample0), -99999);
            else begin
                e = sample_q0.pop_front();
                check("sample_g0", int'(sample0), e.value);
                check("sample_cycle_g0", cyc, e.due);
            end
        end
        if (fe0) begin
            if (err_q0.size() == 0) check("unexpected_error_g0", 1, 0);
            else begin
                e = err_q0.pop_front();
                check("error_cycle_g0", cyc, e.due);
            end
        end
    end

    // Sample/error monitor for the gain-shift-3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (sv3) begin
            if (sample_q3.size() == 0) check("unexpected_sample_g3", int'(sample3), -99999);
            else begin
                e = sample_q3.pop_front();
                check("sample_g3", int'(sample3), e.value);
                check("sample_cycle_g3", cyc, e.due);
            end
        end
        if (fe3) begin
            if (err_q3.size() == 0) check("unexpected_error_g3", 1, 0);
            else begin
                e = err_q3.pop_front();
                check("error_cycle_g3", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        idle();
        @(negedge clk);
        check("reset_sample_g0", int'(sample0), 0);
        check("reset_sample_g3", int'(sample3), 0);
        check("reset_sv", int'(sv0) + int'(sv3), 0);
        check("reset_fe", int'(fe0) + int'(fe3), 0);
        check("reset_wb_id", int'(wb_id0) + int'(wb_id3), 0);
        check("reset_wb_val", int'(wb_val0) + int'(wb_val3), 0);

        // Writeback gating while still waiting for frame sync.
        drive(1'b1, 'h25, 1'b0, 1'b0, 5000, 1'b0);
        drive(1'b1, 'h25, 1'b0, 1'b1, 5000, 1'b0);
        repeat (3) idle();
        drive(1'b1, 'h13, 1'b1, 1'b1, -1234, 1'b0);
        repeat (2) idle();

        // Reset mid-frame at ID 40, resume at 41: nothing may come out of the broken frame.
        for (int id = 0; id < 40; id++) slot(id, id == 0, 16000);
        drive(1'b1, 40, 1'b0, 1'b1, 1000, 1'b1);
        for (int id = 41; id < 128; id++) slot(id, 1'b0, 1000);
        repeat (3) idle();
        check("post_reset_sample_g0", int'(sample0), 0);
        check("post_reset_sample_g3", int'(sample3), 0);

        // Single carrier 16000: 16000 unshifted, 2000 after >>>3.
        frame(1, 16000, 1'b1, -1, 0, 16000, 2000);
        // Eight carriers at full scale: sum 262136 clamps to 32767; >>>3 gives exactly 32767.
        frame(8, 32767, 1'b1, -1, 0, 32767, 32767);
        // Eight carriers at negative full scale: -262144 clamps; >>>3 gives exactly -32768.
        frame(8, -32768, 1'b1, -1, 0, -32768, -32768);
        // Three carriers at -100: -300, and arithmetic shift floors to -38.
        frame(3, -100, 1'b1, -1, 0, -300, -38);
        // Carriers with note off contribute nothing.
        frame(8, 32767, 1'b0, -1, 0, 0, 0);

        // Sequence fault: 5 then 7 -> one error, frame dropped, resync on next ID 0.
        for (int id = 0; id <= 5; id++) slot(id, id == 0, 16000);
        slot(7, 1'b0, 1000);
        expect_error();
        for (int id = 8; id < 128; id++) slot(id, 1'b0, 1000);
        frame(3, -100, 1'b1, -1, 0, -300, -38);

        // Gap of 3 idle slots after ID 63: same sample, pulse shifted with the last slot.
        frame(1, 16000, 1'b1, 63, 3, 16000, 2000);

        repeat (6) idle();
        @(negedge clk);
        check("pending_samples_g0", sample_q0.size(), 0);
        check("pending_samples_g3", sample_q3.size(), 0);
        check("pending_errors_g0", err_q0.size(), 0);
        check("pending_errors_g3", err_q3.size(), 0);
        check("last_sample_hold_g0", int'(sample0), 16000);
        check("last_sample_hold_g3", int'(sample3), 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
